// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register (ID/EX, EX/MEM, ...) carrying a PC, a packed
//   control word and NUM_OPS operand channels across a valid/ready handshake.
//   Operands can be replaced by forwarded values at the moment of capture.
//   A saturating counter records every cycle in which no valid entry is
//   presented downstream.
//
//   Build option: define SKID_BUF_EN to get a two-entry (main + skid) stage
//   whose in_ready has no combinational path from out_ready. Without it the
//   stage holds one entry and in_ready = !out_valid | out_ready.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               squash every stored entry at the next edge
//   in_valid/in_ready   upstream handshake
//   in_pc/in_ctrl/in_op upstream payload, operand k at [k*OP_W +: OP_W]
//   fwd_en/fwd_data     per-channel operand override applied at capture
//   out_valid/out_ready downstream handshake (out_ready=0 stalls)
//   out_pc/out_ctrl/out_op registered payload (out_ctrl is 0 when invalid)
//   bubble_cnt          saturating count of edges seen with out_valid=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int PC_W    = 32,
    parameter int CTRL_W  = 64,
    parameter int NUM_OPS = 2,
    parameter int OP_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_W-1:0]           in_pc,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_OPS*OP_W-1:0]   in_op,
    input  logic [NUM_OPS-1:0]        fwd_en,
    input  logic [NUM_OPS*OP_W-1:0]   fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_W-1:0]           out_pc,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_OPS*OP_W-1:0]   out_op,
    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int OPS_W = NUM_OPS * OP_W;

    // Per-channel operand select: forwarded value wins where fwd_en is set.
    function automatic logic [OPS_W-1:0] fwd_merge(
        input logic [OPS_W-1:0]   op_v,
        input logic [NUM_OPS-1:0] en_v,
        input logic [OPS_W-1:0]   fwd_v
    );
        logic [OPS_W-1:0] res;
        res = op_v;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (en_v[k]) begin
                res[k*OP_W +: OP_W] = fwd_v[k*OP_W +: OP_W];
            end else begin
                res[k*OP_W +: OP_W] = op_v[k*OP_W +: OP_W];
            end
        end
        return res;
    endfunction

    logic              main_valid_q, main_valid_d;
    logic [PC_W-1:0]   main_pc_q,    main_pc_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [OPS_W-1:0]  main_op_q,    main_op_d;
    logic [CNT_W-1:0]  bub_q,        bub_d;
    logic [OPS_W-1:0]  cap_op_s;
    logic              accept_s;
    logic              in_ready_s;

    assign cap_op_s = fwd_merge(in_op, fwd_en, fwd_data);
    assign accept_s = in_valid & in_ready_s;

`ifdef SKID_BUF_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [OPS_W-1:0]  skid_op_q,   skid_op_d;

    // in_ready depends only on stored state (and reset), never on out_ready.
    assign in_ready_s = ~rst & (state_q != ST_FULL2);

    // Next-state / datapath steering for the main + skid pair.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_ctrl_d = main_ctrl_q;
        main_op_d   = main_op_q;
        skid_pc_d   = skid_pc_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_op_d   = skid_op_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_pc_d   = {PC_W{1'b0}};
            main_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d     = ST_FULL1;
                        main_pc_d   = in_pc;
                        main_ctrl_d = in_ctrl;
                        main_op_d   = cap_op_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL1: begin
                    if (accept_s && out_ready) begin
                        main_pc_d   = in_pc;
                        main_ctrl_d = in_ctrl;
                        main_op_d   = cap_op_s;
                    end else if (accept_s) begin
                        // Downstream stalled: park the younger entry in skid.
                        state_d     = ST_FULL2;
                        skid_pc_d   = in_pc;
                        skid_ctrl_d = in_ctrl;
                        skid_op_d   = cap_op_s;
                    end else if (out_ready) begin
                        state_d     = ST_EMPTY;
                        main_pc_d   = {PC_W{1'b0}};
                        main_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d = ST_FULL1;
                    end
                end
                ST_FULL2: begin
                    if (out_ready) begin
                        state_d     = ST_FULL1;
                        main_pc_d   = skid_pc_q;
                        main_ctrl_d = skid_ctrl_q;
                        main_op_d   = skid_op_q;
                    end else begin
                        state_d = ST_FULL2;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_pc_d   = {PC_W{1'b0}};
                    main_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end
        main_valid_d = (state_d != ST_EMPTY);
    end

    // State and skid-entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            skid_pc_q   <= {PC_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_op_q   <= {OPS_W{1'b0}};
        end else begin
            state_q     <= state_d;
            skid_pc_q   <= skid_pc_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_op_q   <= skid_op_d;
        end
    end
`else
    // Single entry: a slot frees up in the same cycle it is drained.
    assign in_ready_s = ~rst & (~main_valid_q | out_ready);

    // Next-state for the single main entry.
    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_ctrl_d  = main_ctrl_q;
        main_op_d    = main_op_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_pc_d    = {PC_W{1'b0}};
            main_ctrl_d  = {CTRL_W{1'b0}};
        end else if (accept_s) begin
            main_valid_d = 1'b1;
            main_pc_d    = in_pc;
            main_ctrl_d  = in_ctrl;
            main_op_d    = cap_op_s;
        end else if (main_valid_q && out_ready) begin
            main_valid_d = 1'b0;
            main_pc_d    = {PC_W{1'b0}};
            main_ctrl_d  = {CTRL_W{1'b0}};
        end else begin
            main_valid_d = main_valid_q;
        end
    end
`endif

    // Saturating bubble counter, advanced on the pre-edge out_valid.
    always_comb begin
        if (!main_valid_q && (bub_q != {CNT_W{1'b1}})) begin
            bub_d = bub_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bub_d = bub_q;
        end
    end

    // Main entry and counter registers; ctrl/pc are cleared whenever the
    // entry goes invalid so a squashed slot never drives a write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= {PC_W{1'b0}};
            main_ctrl_q  <= {CTRL_W{1'b0}};
            main_op_q    <= {OPS_W{1'b0}};
            bub_q        <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_ctrl_q  <= main_ctrl_d;
            main_op_q    <= main_op_d;
            bub_q        <= bub_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = main_valid_q;
    assign out_pc     = main_pc_q;
    assign out_ctrl   = main_ctrl_q;
    assign out_op     = main_op_q;
    assign bubble_cnt = bub_q;

endmodule
